vram_arbiter: RTL and testbench

//  Shares one single-port frame-buffer RAM (async read, sync write) between the VGA

---
 rtl/vram_arbiter.sv | 110 +++++++++++
 tb/tb_vram_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Frame-buffer port arbiter: VGA scan-out reads take the single RAM port whenever they
// want it; pixel writes queue in a small FIFO and drain only while the reader is idle.
module vram_arbiter #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic                          vga_rdn,
    input  logic [8:0]                    vga_row,
    input  logic [9:0]                    vga_col,
    input  logic                          vga_vs,
    output logic [DATA_W-1:0]             vga_dout,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [$clog2(FIFO_DEPTH):0]   wr_level,
    output logic                          wr_err,
    output logic [15:0]                   frame_cnt,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_we,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int LIN_W = 20;
    localparam logic [31:0] FB_WORDS = 32'(H_RES * V_RES);

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              err_q, err_d;
    logic              vs_q, vs_d;
    logic [15:0]       frame_q, frame_d;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

    logic [LIN_W-1:0]  vga_lin;
    logic [ADDR_W-1:0] vga_addr;
    logic              accept, in_range, push, pop;

    assign vga_lin  = LIN_W'(vga_row) * LIN_W'(H_RES) + LIN_W'(vga_col);
    assign vga_addr = ADDR_W'(vga_lin);

    // wr_ready depends on registered occupancy only, so a full FIFO refuses even on a pop cycle.
    assign wr_ready = (level_q < LVL_W'(FIFO_DEPTH));
    assign accept   = wr_valid & wr_ready;
    assign in_range = (32'(wr_addr) < FB_WORDS);
    assign push     = accept & in_range;
    assign pop      = vga_rdn & (level_q != '0);

    assign mem_we    = pop;
    assign mem_addr  = pop ? fifo_addr_q[rd_ptr_q] : vga_addr;
    assign mem_wdata = fifo_data_q[rd_ptr_q];
    assign vga_dout  = mem_rdata;

    assign wr_level  = level_q;
    assign wr_err    = err_q;
    assign frame_cnt = frame_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        err_d    = err_q;
        vs_d     = vga_vs;
        frame_d  = frame_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if (accept && !in_range) err_d = 1'b1;
        if (vga_vs && !vs_q) frame_d = frame_q + 16'd1;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            err_q    <= 1'b0;
            vs_q     <= 1'b1;
            frame_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            err_q    <= err_d;
            vs_q     <= vs_d;
            frame_q  <= frame_d;
        end
    end

    // Entry storage carries no reset; validity is tracked solely by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr;
            fifo_data_q[wr_ptr_q] <= wr_data;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed and random bench for vram_arbiter with a behavioural RAM and a write-order scoreboard.
module tb_vram_arbiter;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 12;
    localparam int FB_WORDS = 640 * 480;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              clrn = 1'b0;
    logic              vga_rdn = 1'b1;
    logic [8:0]        vga_row = '0;
    logic [9:0]        vga_col = '0;
    logic              vga_vs = 1'b1;
    logic [DATA_W-1:0] vga_dout;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [2:0]        wr_level;
    logic              wr_err;
    logic [15:0]       frame_cnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    wr_t sb[$];
    int errors = 0;
    int checks = 0;

    vram_arbiter dut (
        .clk(clk), .clrn(clrn), .vga_rdn(vga_rdn), .vga_row(vga_row), .vga_col(vga_col),
        .vga_vs(vga_vs), .vga_dout(vga_dout), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_level(wr_level), .wr_err(wr_err),
        .frame_cnt(frame_cnt), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected writes are queued at the handshake edge, in acceptance order.
    always @(posedge clk) begin
        if (clrn && wr_valid && wr_ready && int'(wr_addr) < FB_WORDS)
            sb.push_back('{addr: wr_addr, data: wr_data});
    end

    always @(negedge clk) begin
        if (clrn && mem_we) begin
            wr_t e;
            check("we_while_vga_read", {31'd0, vga_rdn}, 32'd1);
            if (sb.size() == 0) begin
                check("unexpected_write", {13'd0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("write_order", {1'b0, mem_addr, mem_wdata}, {1'b0, e.addr, e.data});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_one(input int a, input int d);
        wr_addr  = ADDR_W'(a);
        wr_data  = DATA_W'(d);
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        vga_rdn = 1'b1;
        while (wr_level != 0 && n < 50) begin
            step();
            n++;
        end
        check("drain_level", {29'd0, wr_level}, 32'd0);
        check("drain_queue", sb.size(), 32'd0);
    endtask

    initial begin
        // 1: reset with a pending request
        wr_valid = 1'b1;
        wr_addr  = 19'd100;
        @(negedge clk);
        check("rst_ready", {31'd0, wr_ready}, 32'd1);
        check("rst_level", {29'd0, wr_level}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_frame", {16'd0, frame_cnt}, 32'd0);
        check("rst_err", {31'd0, wr_err}, 32'd0);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        clrn = 1'b1;
        step();

        // 2: VGA address and read passthrough
        write_one(1285, 12'hABC);
        drain();
        vga_rdn = 1'b0; vga_row = 9'd2; vga_col = 10'd5;
        @(negedge clk);
        check("vga_addr", {13'd0, mem_addr}, 32'd1285);
        check("vga_dout", {20'd0, vga_dout}, 32'hABC);
        check("vga_no_we", {31'd0, mem_we}, 32'd0);
        vga_row = 9'd479; vga_col = 10'd639;
        #1 check("vga_addr_last", {13'd0, mem_addr}, 32'd307199);

        // 3: fill while VGA reads, then drain in four consecutive cycles
        step();
        for (int i = 0; i < 4; i++) write_one(10 + i, 12'h111 * (i + 1));
        @(negedge clk);
        check("full_level", {29'd0, wr_level}, 32'd4);
        check("full_ready", {31'd0, wr_ready}, 32'd0);
        check("full_no_we", {31'd0, mem_we}, 32'd0);
        step();
        vga_rdn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("burst_we", {31'd0, mem_we}, 32'd1);
            step();
        end
        @(negedge clk);
        check("burst_done_level", {29'd0, wr_level}, 32'd0);
        check("burst_done_we", {31'd0, mem_we}, 32'd0);

        // 4: full FIFO with a waiting writer; same-address write lands last
        step();
        vga_rdn = 1'b0;
        for (int i = 0; i < 4; i++) write_one(20 + i, 12'h200 + i);
        wr_addr = 19'd20; wr_data = 12'h555; wr_valid = 1'b1; vga_rdn = 1'b1;
        @(negedge clk);
        check("full_pop_ready", {31'd0, wr_ready}, 32'd0);
        check("full_pop_we", {31'd0, mem_we}, 32'd1);
        step();
        @(negedge clk);
        check("after_pop_level", {29'd0, wr_level}, 32'd3);
        check("after_pop_ready", {31'd0, wr_ready}, 32'd1);
        step();
        wr_valid = 1'b0;
        @(negedge clk);
        check("push_pop_level", {29'd0, wr_level}, 32'd3);
        step();
        drain();
        vga_rdn = 1'b0; vga_row = 9'd0; vga_col = 10'd20;
        @(negedge clk);
        check("last_write_wins", {20'd0, vga_dout}, 32'h555);

        // 5: out-of-range write, and frame counting
        step();
        write_one(FB_WORDS, 12'hFFF);
        @(negedge clk);
        check("oor_level", {29'd0, wr_level}, 32'd0);
        check("oor_err", {31'd0, wr_err}, 32'd1);
        step();
        vga_rdn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vga_vs = 1'b0; step(); step();
            vga_vs = 1'b1; step(); step();
        end
        @(negedge clk);
        check("oor_no_we", {31'd0, mem_we}, 32'd0);
        check("err_sticky", {31'd0, wr_err}, 32'd1);
        check("frame_cnt", {16'd0, frame_cnt}, 32'd3);
        step();
        clrn = 1'b0;
        #1 check("err_cleared", {31'd0, wr_err}, 32'd0);
        check("frame_cleared", {16'd0, frame_cnt}, 32'd0);
        step();
        clrn = 1'b1;
        step();

        // 6: random traffic with a mid-run reset
        for (int c = 0; c < 10000; c++) begin
            vga_rdn  = ($urandom_range(0, 3) == 0);
            vga_row  = 9'($urandom_range(0, 479));
            vga_col  = 10'($urandom_range(0, 639));
            wr_valid = ($urandom_range(0, 1) == 1);
            wr_addr  = ADDR_W'($urandom_range(0, FB_WORDS - 1));
            wr_data  = DATA_W'($urandom_range(0, 4095));
            if (c == 5000) begin
                clrn = 1'b0;
                sb.delete();
                @(negedge clk);
                check("midrst_level", {29'd0, wr_level}, 32'd0);
                check("midrst_we", {31'd0, mem_we}, 32'd0);
                step();
                clrn = 1'b1;
            end
            step();
        end
        wr_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
